// File: rtl/axi_lite_master.sv
// AXI4-Lite master that runs one single-beat read or write at a time.
// Every output is a flop, so all valids and readies are computed from the next state.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT_B,
    S_READ_ADDR,
    S_WAIT_R,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                  r_cmd_ready;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_arvalid;
  logic                  r_bready;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;

  logic w_accept;
  logic w_aw_done;
  logic w_w_done;

  assign w_accept  = (r_state == S_IDLE) && r_cmd_ready && cmd_valid;
  // A channel is finished once its valid has dropped or it handshakes this cycle.
  assign w_aw_done = !r_awvalid || m_awready;
  assign w_w_done  = !r_wvalid  || m_wready;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:      if (w_accept) w_state_next = cmd_write ? S_WRITE : S_READ_ADDR;
      S_WRITE:     if (w_aw_done && w_w_done) w_state_next = S_WAIT_B;
      S_WAIT_B:    if (r_bready && m_bvalid) w_state_next = S_RESP;
      S_READ_ADDR: if (r_arvalid && m_arready) w_state_next = S_WAIT_R;
      S_WAIT_R:    if (r_rready && m_rvalid) w_state_next = S_RESP;
      S_RESP:      if (r_rsp_valid && rsp_ready) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cmd_ready <= (w_state_next == S_IDLE);
      r_bready    <= (w_state_next == S_WAIT_B);
      r_rready    <= (w_state_next == S_WAIT_R);
      r_rsp_valid <= (w_state_next == S_RESP);

      if (w_accept) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_awvalid <= cmd_write;
        r_wvalid  <= cmd_write;
        r_arvalid <= !cmd_write;
      end else begin
        if (m_awready) r_awvalid <= 1'b0;
        if (m_wready)  r_wvalid  <= 1'b0;
        if (m_arready) r_arvalid <= 1'b0;
      end

      if (r_state == S_WAIT_B && r_bready && m_bvalid) begin
        r_rsp_rdata <= '0;
        r_rsp_resp  <= m_bresp;
      end
      if (r_state == S_WAIT_R && r_rready && m_rvalid) begin
        r_rsp_rdata <= m_rdata;
        r_rsp_resp  <= m_rresp;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;
  assign m_awvalid = r_awvalid;
  assign m_awaddr  = r_addr;
  assign m_wvalid  = r_wvalid;
  assign m_wdata   = r_wdata;
  assign m_bready  = r_bready;
  assign m_arvalid = r_arvalid;
  assign m_araddr  = r_addr;
  assign m_rready  = r_rready;

endmodule
